rv_multicycle_alu: RTL and testbench
====================================

Name: rv_multicycle_alu

Overview:
- Next-generation integer execution unit for the RISCuinho core. Covers every RV32I ALU operation plus the RV32M multiply/divide set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Uses a valid/ready handshake with a registered result. Basic ops finish in 1 cycle; M ops run a radix-2 iterative datapath of DATA_WIDTH cycles.
- Sits between decode/register-read and writeback, and stalls the pipeline through in_ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two and at least 8.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from B (derived; never overridden).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept an operation
- alu_op  input  16  {funct7, funct3, opcode} operation code
- A  input  DATA_WIDTH  operand 1 (rs1 / PC)
- B  input  DATA_WIDTH  operand 2 (rs2 / immediate)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out  output  DATA_WIDTH  result
- illegal  output  1  qualifies out_valid; high when alu_op is unrecognised

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, illegal=0, iteration counter=0.
- Reset asserted mid-operation aborts the operation. The next cycle is IDLE and the partial result is discarded.
- A transfer is accepted when in_valid && in_ready. Operands and alu_op are latched on acceptance, so later input changes are ignored.
- FSM states and transitions:
  - IDLE: in_ready=1. On accept of a basic op or a special-case M op, go to DONE. On accept of MUL* go to MUL. On accept of DIV*/REM* go to DIV.
  - MUL: shift-add over the |operand| bits, DATA_WIDTH iterations, then sign correction to a 2*DATA_WIDTH product. Then go to DONE.
  - DIV: restoring division on magnitudes, DATA_WIDTH iterations, sign fix-up. Then go to DONE.
  - DONE: out_valid=1; out and illegal are held stable. When out_ready=1, go to IDLE. in_ready=0 here, so there is no overlap.
- Latency from the accept cycle T:
  - Basic op: out_valid at T+1.
  - MUL/DIV: out_valid at T+DATA_WIDTH+1.
  - Throughput is 1 op per 2 cycles minimum (no back-to-back issue).
- Basic ops use the same encoding and semantics as the existing single-cycle ALU:
  - ADD result for ADDI, AUIPC, loads, stores and branches.
  - SUB, AND/OR/XOR (reg and imm forms), SLT/SLTI signed, SLTU/SLTIU unsigned. SLTU (reg form) is supported.
  - LUI returns B.
  - JAL/JALR return A+B.
  - SLT* results are zero-extended 0/1.
- Shifts use only B[SHAMT_WIDTH-1:0]; upper bits of B are ignored. SRA/SRAI are arithmetic; SLL/SRL are logical.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- M-op results:
  - MUL returns the low DATA_WIDTH bits of the product.
  - MULH returns the high half, signed×signed.
  - MULHSU returns the high half, signed A × unsigned B.
  - MULHU returns the high half, unsigned×unsigned.
- Special cases resolve in 1 cycle (IDLE→DONE, out_valid at T+1):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return A.
  - Signed overflow (A = most-negative, B = -1): DIV returns A; REM returns 0.
- REM sign follows the dividend. DIV truncates toward zero.
- Unrecognised alu_op: out=0 and illegal=1, with 1-cycle latency.

Test Plan:
- Reset mid-DIV: accept DIVU 100/7, assert reset at cycle T+10 → next cycle in_ready=1, out_valid=0, out=0. A fresh ADD 2+3 afterwards returns 5 at T'+1.
- Basic ops with out_ready held 1:
  - SUB 5-7 → 0xFFFFFFFE at T+1.
  - SRA 0x80000000 by B=0x21 (shamt=1) → 0xC0000000.
  - SLTU 1<0xFFFFFFFF → 1.
  - in_ready low exactly 1 cycle.
- Multiply: MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
- Multiply: MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Multiply: MUL 0x00010000×0x00010000 → 0.
- Multiply timing: each result has out_valid at exactly T+33.
- Divide: DIV -7/2 → 0xFFFFFFFD (-3) at T+33; REM -7/2 → 0xFFFFFFFF (-1).
- Divide special cases at T+1:
  - DIVU x/0 → 0xFFFFFFFF.
  - REMU 9/0 → 9.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000/-1 → 0.
- Backpressure: hold out_ready=0 for 5 cycles after MUL 6×7 → out=42 stable, out_valid=1 throughout, in_ready=0. Release → IDLE the next cycle.
- Illegal op: alu_op=0xFFFF → out=0, illegal=1 at T+1. A following ADDI clears illegal to 0.

Source files
------------

// File: rtl/rv_multicycle_alu.sv
// rv_multicycle_alu: RV32I ALU plus RV32M multiply/divide behind a
// valid/ready handshake with a registered result.
//
// Basic ops and the 1-cycle M special cases complete in one cycle (IDLE->DONE).
// MUL* runs a radix-2 shift-add multiplier for DATA_WIDTH cycles.
// DIV*/REM* runs a restoring divider for DATA_WIDTH cycles.
// Both multi-cycle ops work on operand magnitudes and fix the sign on the last step.
//
// alu_op packing is {funct7[6:0], funct3[2:0], opcode[6:1]}.
// opcode[0] is always 1 for 32-bit encodings, so it is dropped to fit 16 bits.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid/ready   operation handshake; operands latched on accept
//   alu_op, A, B     operation code and operands
//   out_valid/ready  result handshake; out/illegal held while out_valid
//   out, illegal     result and unrecognised-op flag
module rv_multicycle_alu #(
    parameter  int DATA_WIDTH  = 32,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           alu_op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  illegal
);
    localparam int W = DATA_WIDTH;

    // opcode[6:1]
    localparam logic [5:0] OPC_LOAD   = 6'h01;
    localparam logic [5:0] OPC_OPIMM  = 6'h09;
    localparam logic [5:0] OPC_AUIPC  = 6'h0B;
    localparam logic [5:0] OPC_STORE  = 6'h11;
    localparam logic [5:0] OPC_OP     = 6'h19;
    localparam logic [5:0] OPC_LUI    = 6'h1B;
    localparam logic [5:0] OPC_BRANCH = 6'h31;
    localparam logic [5:0] OPC_JALR   = 6'h33;
    localparam logic [5:0] OPC_JAL    = 6'h37;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                 state;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic [W-1:0]           acc_hi;   // MUL: product high half / DIV: partial remainder
    logic [W-1:0]           acc_lo;   // MUL: multiplier/product low / DIV: dividend/quotient
    logic [W-1:0]           mcand;    // MUL: |multiplicand| / DIV: |divisor|
    logic                   neg_res;  // negate product / quotient
    logic                   neg_rem;  // negate remainder (follows dividend)
    logic                   sel;      // MUL: take high half / DIV: take remainder

    // ---------------- decode and single-cycle results ----------------
    logic [6:0] f7;
    logic [2:0] f3;
    logic [5:0] opc;
    assign f7  = alu_op[15:9];
    assign f3  = alu_op[8:6];
    assign opc = alu_op[5:0];

    logic [SHAMT_WIDTH-1:0] shamt;
    logic [W-1:0] add_r, sub_r, slt_r, sltu_r, sll_r, srl_r, sra_r;
    assign shamt  = B[SHAMT_WIDTH-1:0];
    assign add_r  = A + B;
    assign sub_r  = A - B;
    assign slt_r  = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
    assign sltu_r = {{(W-1){1'b0}}, A < B};
    assign sll_r  = A << shamt;
    assign srl_r  = A >> shamt;
    assign sra_r  = $unsigned($signed(A) >>> shamt);

    logic         is_mul, is_div, is_ill;
    logic [W-1:0] quick_res;
    logic         a_sgn, b_sgn, div_zero, div_ovf;
    logic [W-1:0] mag_a, mag_b;

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_ill    = 1'b0;
        quick_res = '0;
        case (opc)
            OPC_LUI: quick_res = B;
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE:
                quick_res = add_r;
            OPC_OPIMM: begin
                case (f3)
                    3'd0: quick_res = add_r;
                    3'd2: quick_res = slt_r;
                    3'd3: quick_res = sltu_r;
                    3'd4: quick_res = A ^ B;
                    3'd6: quick_res = A | B;
                    3'd7: quick_res = A & B;
                    3'd1: if (f7 == 7'h00) quick_res = sll_r; else is_ill = 1'b1;
                    default: begin
                        if (f7 == 7'h00)      quick_res = srl_r;
                        else if (f7 == 7'h20) quick_res = sra_r;
                        else                  is_ill = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0:    quick_res = add_r;
                        3'd1:    quick_res = sll_r;
                        3'd2:    quick_res = slt_r;
                        3'd3:    quick_res = sltu_r;
                        3'd4:    quick_res = A ^ B;
                        3'd5:    quick_res = srl_r;
                        3'd6:    quick_res = A | B;
                        default: quick_res = A & B;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    quick_res = sub_r;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    quick_res = sra_r;
                end else if (f7 == 7'h01) begin
                    is_mul = !f3[2];
                    is_div = f3[2];
                end else begin
                    is_ill = 1'b1;
                end
            end
            default: is_ill = 1'b1;
        endcase

        // Operand signedness: MULH/MULHSU/DIV/REM take A signed; MULH/DIV/REM take B signed.
        a_sgn = A[W-1] && (is_mul ? (f3 == 3'd1 || f3 == 3'd2) : !f3[0]);
        b_sgn = B[W-1] && (is_mul ? (f3 == 3'd1) : !f3[0]);
        mag_a = a_sgn ? -A : A;
        mag_b = b_sgn ? -B : B;

        div_zero = is_div && (B == '0);
        div_ovf  = is_div && !f3[0] && (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
        if (div_zero)
            quick_res = f3[1] ? A : '1;
        else if (div_ovf)
            quick_res = f3[1] ? '0 : A;
    end

    // ---------------- iterative step logic ----------------
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_hi_n, mul_lo_n;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   mul_res;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign mul_hi_n = mul_sum[W:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[W-1:1]};
    assign prod_s   = neg_res ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
    assign mul_res  = sel ? prod_s[2*W-1:W] : prod_s[W-1:0];

    logic [W:0]   div_rs;
    logic         div_ge;
    logic [W-1:0] div_hi_n, div_lo_n, div_res;

    assign div_rs   = {acc_hi, acc_lo[W-1]};
    assign div_ge   = div_rs >= {1'b0, mcand};
    assign div_hi_n = div_ge ? W'(div_rs - {1'b0, mcand}) : div_rs[W-1:0];
    assign div_lo_n = {acc_lo[W-2:0], div_ge};
    assign div_res  = sel ? (neg_rem ? -div_hi_n : div_hi_n)
                          : (neg_res ? -div_lo_n : div_lo_n);

    logic last_iter;
    assign last_iter = (cnt == SHAMT_WIDTH'(W - 1));

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            illegal   <= 1'b0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            sel       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        neg_res  <= a_sgn ^ b_sgn;
                        neg_rem  <= a_sgn;
                        sel      <= is_mul ? (f3 != 3'd0) : f3[1];
                        if (is_mul) begin
                            acc_hi <= '0;
                            acc_lo <= mag_b;
                            mcand  <= mag_a;
                            state  <= S_MUL;
                        end else if (is_div && !div_zero && !div_ovf) begin
                            acc_hi <= '0;
                            acc_lo <= mag_a;
                            mcand  <= mag_b;
                            state  <= S_DIV;
                        end else begin
                            out       <= is_ill ? '0 : quick_res;
                            illegal   <= is_ill;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        out       <= mul_res;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc_hi <= div_hi_n;
                    acc_lo <= div_lo_n;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        out       <= div_res;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_multicycle_alu.sv
// Directed bench for rv_multicycle_alu (DATA_WIDTH=32).
// alu_op = {funct7, funct3, opcode[6:1]}; codes below are hand-packed.
module tb_rv_multicycle_alu;
    localparam logic [15:0] OP_ADD    = 16'h0019;
    localparam logic [15:0] OP_ADDI   = 16'h0009;
    localparam logic [15:0] OP_XORI   = 16'h0109;
    localparam logic [15:0] OP_LUI    = 16'h001B;
    localparam logic [15:0] OP_SUB    = 16'h4019;
    localparam logic [15:0] OP_SRA    = 16'h4159;
    localparam logic [15:0] OP_SLTU   = 16'h00D9;
    localparam logic [15:0] OP_MUL    = 16'h0219;
    localparam logic [15:0] OP_MULH   = 16'h0259;
    localparam logic [15:0] OP_MULHSU = 16'h0299;
    localparam logic [15:0] OP_MULHU  = 16'h02D9;
    localparam logic [15:0] OP_DIV    = 16'h0319;
    localparam logic [15:0] OP_DIVU   = 16'h0359;
    localparam logic [15:0] OP_REM    = 16'h0399;
    localparam logic [15:0] OP_REMU   = 16'h03D9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] alu_op = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    rv_multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .A(A), .B(B), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Offer one op; returns just after the accept edge with inputs scrambled.
    task automatic issue(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = op; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; alu_op = OP_ADD;
    endtask

    // Latency in cycles relative to the accept cycle T (1 = T+1); capped at 100.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'h0 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b out=%h illegal=%b, want 1 0 0 0",
                     in_ready, out_valid, out, illegal);
        end
    endtask

    task automatic test_basic;
        logic [15:0] ops [6] = '{OP_SUB, OP_SRA, OP_SLTU, OP_XORI, OP_LUI, OP_ADD};
        logic [31:0] as  [6] = '{32'd5, 32'h80000000, 32'd1, 32'hF0F0F0F0, 32'h0BAD0BAD, 32'hFFFFFFFF};
        logic [31:0] bs  [6] = '{32'd7, 32'h00000021, 32'hFFFFFFFF, 32'h0FF00FF0, 32'h12345000, 32'd1};
        logic [31:0] ex  [6] = '{32'hFFFFFFFE, 32'hC0000000, 32'd1, 32'hFF00FF00, 32'h12345000, 32'h0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_out(lat);
            tests++;
            if (lat != 1 || out !== ex[i] || illegal !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL basic[%0d]: lat=%0d out=%h ill=%b in_ready=%b, want lat=1 out=%h ill=0 in_ready=0",
                         i, lat, out, illegal, in_ready, ex[i]);
            end
            @(posedge clk); #1;
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL basic_ready[%0d]: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_div;
        int lat;
        issue(OP_DIVU, 32'd100, 32'd7);   // accepted in cycle T; now in T+1
        repeat (9) @(posedge clk);        // now in cycle T+10
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_div: in_ready=%b out_valid=%b out=%h, want 1 0 0",
                     in_ready, out_valid, out);
        end
        issue(OP_ADD, 32'd2, 32'd3);
        wait_out(lat);
        tests++;
        if (lat != 1 || out !== 32'd5) begin
            fails++;
            $display("FAIL add_after_reset: lat=%0d out=%h, want lat=1 out=5", lat, out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_div;
        logic [15:0] ops [8] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU, OP_MUL, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] as  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF,
                                 32'hFFFFFFFD, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100};
        logic [31:0] bs  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'd2,
                                 32'd5, 32'd2, 32'd2, 32'd7};
        logic [31:0] ex  [8] = '{32'h0, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF,
                                 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
        int lat;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_out(lat);
            tests++;
            if (lat != 33 || out !== ex[i] || illegal !== 1'b0) begin
                fails++;
                $display("FAIL muldiv[%0d]: lat=%0d out=%h ill=%b, want lat=33 out=%h ill=0",
                         i, lat, out, illegal, ex[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_special;
        logic [15:0] ops [5] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM};
        logic [31:0] as  [5] = '{32'h12345678, 32'd9, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] bs  [5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [31:0] ex  [5] = '{32'hFFFFFFFF, 32'd9, 32'h80000000, 32'h0, 32'hFFFFFFF9};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_out(lat);
            tests++;
            if (lat != 1 || out !== ex[i]) begin
                fails++;
                $display("FAIL div_special[%0d]: lat=%0d out=%h, want lat=1 out=%h", i, lat, out, ex[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        issue(OP_MUL, 32'd6, 32'd7);
        wait_out(lat);
        tests++;
        if (lat != 33) begin
            fails++;
            $display("FAIL bp_latency: lat=%0d, want 33", lat);
        end
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (out !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: out=%h out_valid=%b in_ready=%b, want 2a 1 0",
                         c, out, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal;
        int lat;
        issue(16'hFFFF, 32'h11111111, 32'h22222222);
        wait_out(lat);
        tests++;
        if (lat != 1 || out !== 32'h0 || illegal !== 1'b1) begin
            fails++;
            $display("FAIL illegal: lat=%0d out=%h illegal=%b, want lat=1 out=0 illegal=1", lat, out, illegal);
        end
        @(posedge clk); #1;
        issue(OP_ADDI, 32'd1, 32'd2);
        wait_out(lat);
        tests++;
        if (lat != 1 || out !== 32'd3 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL illegal_clear: lat=%0d out=%h illegal=%b, want lat=1 out=3 illegal=0", lat, out, illegal);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_div();
        test_mul_div();
        test_div_special();
        test_backpressure();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
